// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module   : adder_share_arbiter
// Brief    : Round-robin sharing of one 16-bit carry-lookahead adder between
//            two valid/ready requesters, with registered operands and result.
//            Optional grant counters are enabled by the ADDER_ARB_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// 16-bit carry-lookahead adder: 4-bit lookahead groups, carry passed between groups.
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  w_g;
  logic [WIDTH-1:0]  w_p;
  logic [WIDTH-1:0]  w_c;
  logic [c_GROUPS:0] w_gc;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = 1'b0;

  for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_grp
    localparam int c_B = gi * 4;
    logic w_grp_g;
    logic w_grp_p;

    assign w_c[c_B]   = w_gc[gi];
    assign w_c[c_B+1] = w_g[c_B] | (w_p[c_B] & w_gc[gi]);
    assign w_c[c_B+2] = w_g[c_B+1] | (w_p[c_B+1] & w_g[c_B])
                      | (w_p[c_B+1] & w_p[c_B] & w_gc[gi]);
    assign w_c[c_B+3] = w_g[c_B+2] | (w_p[c_B+2] & w_g[c_B+1])
                      | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                      | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_gc[gi]);

    assign w_grp_g = w_g[c_B+3] | (w_p[c_B+3] & w_g[c_B+2])
                   | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                   | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);
    assign w_grp_p = &w_p[c_B+3:c_B];

    assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_gc[gi]);
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_gc[c_GROUPS];

endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf,
`ifdef ADDER_ARB_STATS_EN
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt,
`endif
  output logic             res_id
);

  if (WIDTH != 16 || CNT_W < 1) begin : g_param_check
    $error("adder_share_arbiter: WIDTH must be 16 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic             r_id;
  logic             r_res_valid;

  logic             w_grant;
  logic             w_idle;
  logic             w_hs;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;

  // On a tie the requester that did not win last time is served.
  assign w_grant = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_idle  = (r_state == S_IDLE) & ~rst;

  assign req0_ready = w_idle & ~w_grant & req0_valid;
  assign req1_ready = w_idle &  w_grant & req1_valid;
  assign w_hs       = req0_ready | req1_ready;

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_op_a),
    .b    (r_op_b),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_id      <= 1'b0;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_id         <= 1'b0;
      r_res_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op_a       <= w_grant ? req1_a : req0_a;
            r_op_b       <= w_grant ? req1_b : req0_b;
            r_op_id      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum       <= w_add_sum;
          r_ovf       <= w_add_cout;
          r_id        <= r_op_id;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_sum;
  assign res_ovf   = r_ovf;
  assign res_id    = r_id;

`ifdef ADDER_ARB_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_grant0_cnt;
  logic [CNT_W-1:0] r_grant1_cnt;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
    end else begin
      if (req0_ready && r_grant0_cnt != c_CNT_MAX) begin
        r_grant0_cnt <= r_grant0_cnt + 1'b1;
      end
      if (req1_ready && r_grant1_cnt != c_CNT_MAX) begin
        r_grant1_cnt <= r_grant1_cnt + 1'b1;
      end
    end
  end

  assign grant0_cnt = r_grant0_cnt;
  assign grant1_cnt = r_grant1_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed table, corner sequences,
// and randomized transactions against a transaction-level reference model.
`default_nettype none

module tb_adder_share_arbiter;

`ifdef ADDER_ARB_STATS_EN
  localparam int CNTW = 2;
`else
  localparam int CNTW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_ovf, res_id;
  logic [15:0] res_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [CNTW-1:0] grant0_cnt, grant1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who won the last grant, and grant tallies.
  logic m_last;
  int   m_cnt0, m_cnt1;

  typedef struct {
    logic        v0, v1;
    logic [15:0] a0, b0, a1, b1;
    int          stall;
    logic        id;
    logic [15:0] sum;
    logic        ovf;
  } vec_t;

  vec_t tbl[8];

  adder_share_arbiter #(.WIDTH(16), .CNT_W(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_ovf    (res_ovf),
`ifdef ADDER_ARB_STATS_EN
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt),
`endif
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_stats();
`ifdef ADDER_ARB_STATS_EN
    check("grant0_cnt", 32'(grant0_cnt), 32'(m_cnt0));
    check("grant1_cnt", 32'(grant1_cnt), 32'(m_cnt1));
`endif
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNTW) - 1) ? v : v + 1;
  endfunction

  // One full transaction starting in IDLE; exp_* are the required result.
  task automatic txn(input logic v0, input logic v1,
                     input logic [15:0] a0, input logic [15:0] b0,
                     input logic [15:0] a1, input logic [15:0] b1,
                     input int stall, input logic exp_id,
                     input logic [15:0] exp_sum, input logic exp_ovf);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = 1'b0;
    #1;
    check("idle_req0_ready", 32'(req0_ready), 32'(v0 && !exp_id));
    check("idle_req1_ready", 32'(req1_ready), 32'(v1 && exp_id));
    tick();
    m_last = exp_id;
    if (exp_id) begin
      req1_valid = 1'b0;
      m_cnt1 = sat_inc(m_cnt1);
    end else begin
      req0_valid = 1'b0;
      m_cnt0 = sat_inc(m_cnt0);
    end
    #1;
    check("calc_readies", 32'({req0_ready, req1_ready}), 32'd0);
    check("calc_res_valid", 32'(res_valid), 32'd0);
    tick();
    check("hold_res_valid", 32'(res_valid), 32'd1);
    check("res_sum", 32'(res_sum), 32'(exp_sum));
    check("res_ovf", 32'(res_ovf), 32'(exp_ovf));
    check("res_id", 32'(res_id), 32'(exp_id));
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res", 32'({res_id, res_ovf, res_sum}), 32'({exp_id, exp_ovf, exp_sum}));
      check("stall_readies", 32'({req0_ready, req1_ready}), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("consumed_res_valid", 32'(res_valid), 32'd0);
    check_stats();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 0, 1'b0, 16'h1235, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 0, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 0, 1'b1, 16'h0000, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 16'h0001, 16'h0002, 16'h1111, 16'h2222, 0, 1'b0, 16'h0003, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h4000, 16'h4000, 16'h7FFF, 16'h0001, 0, 1'b1, 16'h8000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 1'b0, 16'hFFFE, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 16'hABCD, 16'h1111, 0, 1'b1, 16'hBCDE, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h00FF, 16'hFF01, 16'h0000, 16'h0000, 5, 1'b0, 16'h0000, 1'b1};

    // Reset with both requesters asserting valid.
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
    req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);
    end
    check("rst_res_regs", 32'({res_id, res_ovf, res_sum}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
    check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    tick();
    check_stats();

    foreach (tbl[i])
      txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
          tbl[i].stall, tbl[i].id, tbl[i].sum, tbl[i].ovf);

    // Reset pulsed while the operands sit in the calculate stage.
    req0_valid = 1'b1; req0_a = 16'h5555; req0_b = 16'h1111;
    #1;
    check("pre_calc_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      check("dropped_res_valid", 32'(res_valid), 32'd0);
      tick();
    end
    check("dropped_res_regs", 32'({res_id, res_ovf, res_sum}), 32'd0);
    check_stats();
    txn(1'b1, 1'b0, 16'h0F0F, 16'h0101, 16'h0, 16'h0, 0, 1'b0, 16'h1010, 1'b0);

`ifdef ADDER_ARB_STATS_EN
    // Saturation of the req0 counter, then clear on reset.
    for (int k = 0; k < 5; k++)
      txn(1'b1, 1'b0, 16'(k), 16'h0010, 16'h0, 16'h0, 0, 1'b0, 16'(k + 16), 1'b0);
    check("sat_grant0_cnt", 32'(grant0_cnt), 32'd3);
    check("sat_grant1_cnt", 32'(grant1_cnt), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    check("clr_grant0_cnt", 32'(grant0_cnt), 32'd0);
    check("clr_grant1_cnt", 32'(grant1_cnt), 32'd0);
`endif

    // Randomized traffic against the transaction-level model.
    for (int it = 0; it < 60; it++) begin
      logic        v0, v1, gid;
      logic [15:0] a0, b0, a1, b1, ga, gb;
      logic [16:0] full;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      if (!v0 && !v1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("rnd_idle_readies", 32'({req0_ready, req1_ready}), 32'd0);
        tick();
      end else begin
        gid  = (v0 && v1) ? !m_last : v1;
        ga   = gid ? a1 : a0;
        gb   = gid ? b1 : b0;
        full = {1'b0, ga} + {1'b0, gb};
        txn(v0, v1, a0, b0, a1, b1, int'($urandom_range(0, 2)), gid, full[15:0], full[16]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
